threewire_cmd_queue: RTL and testbench

Command queue and sequencer that feeds `threewire_master_ctrl`. It buffers register read/write requests from the host-side logic in a small FIFO and issues them one at a time to the 3-wire master. It holds the master's address, data and mode inputs stable for the whole bus operation and returns read data, or a timeout error, on a valid/ready response port.

---
 rtl/threewire_cmd_queue_if.sv | 26 ++
 rtl/threewire_cmd_queue.sv | 162 ++++++++++++++++
 tb/tb_threewire_cmd_queue.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/threewire_cmd_queue_if.sv
// Host-side request/response bundle for threewire_cmd_queue.
// The queue uses the slave modport. The host logic uses the master modport.
interface threewire_cmd_queue_if #(
    parameter int unsigned TWQ_ADDRESS_BITS = 10,
    parameter int unsigned TWQ_DATA_BITS    = 32
);
    logic                        in_req_valid;
    logic                        out_req_ready;
    logic                        in_req_wr;
    logic [TWQ_ADDRESS_BITS-1:0] in_req_addr;
    logic [TWQ_DATA_BITS-1:0]    in_req_wdata;
    logic                        out_rsp_valid;
    logic                        in_rsp_ready;
    logic [TWQ_DATA_BITS-1:0]    out_rsp_data;
    logic                        out_rsp_err;

    modport master (
        output in_req_valid, in_req_wr, in_req_addr, in_req_wdata, in_rsp_ready,
        input  out_req_ready, out_rsp_valid, out_rsp_data, out_rsp_err
    );

    modport slave (
        input  in_req_valid, in_req_wr, in_req_addr, in_req_wdata, in_rsp_ready,
        output out_req_ready, out_rsp_valid, out_rsp_data, out_rsp_err
    );
endinterface

// File: rtl/threewire_cmd_queue.sv
// Command FIFO and sequencer that drives threewire_master_ctrl one operation at a time.
// The optional watchdog is built only when THREEWIRE_QUEUE_TIMEOUT_EN is defined.
module threewire_cmd_queue #(
    parameter int unsigned TWQ_ADDRESS_BITS    = 10,
    parameter int unsigned TWQ_DATA_BITS       = 32,
    parameter int unsigned TWQ_FIFO_DEPTH_LOG2 = 2,
    parameter int unsigned TWQ_TIMEOUT_CYCLES  = 4096
) (
    input  logic                           in_clk,
    input  logic                           in_rst_n,
    threewire_cmd_queue_if.slave           host,
    output logic [TWQ_FIFO_DEPTH_LOG2:0]   out_fifo_level,
    output logic                           out_busy,
    output logic                           out_tw_start,
    output logic                           out_tw_mode_wr,
    output logic [TWQ_ADDRESS_BITS-1:0]    out_tw_addr,
    output logic [TWQ_DATA_BITS-1:0]       out_tw_wr_data,
    input  logic [TWQ_DATA_BITS-1:0]       in_tw_rd_data,
    input  logic                           in_tw_in_progress
);
    localparam int unsigned Depth     = 1 << TWQ_FIFO_DEPTH_LOG2;
    localparam int unsigned EntryBits = 1 + TWQ_ADDRESS_BITS + TWQ_DATA_BITS;
    localparam logic [TWQ_FIFO_DEPTH_LOG2-1:0] PtrOne = TWQ_FIFO_DEPTH_LOG2'(1);
    localparam logic [TWQ_FIFO_DEPTH_LOG2:0]   LevelOne  = (TWQ_FIFO_DEPTH_LOG2 + 1)'(1);
    localparam logic [TWQ_FIFO_DEPTH_LOG2:0]   LevelFull = {1'b1, {TWQ_FIFO_DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StWaitBusy = 2'd1;
    localparam logic [1:0] StWaitDone = 2'd2;

    logic [EntryBits-1:0]           fifo_mem [Depth];
    logic [TWQ_FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [TWQ_FIFO_DEPTH_LOG2:0]   level_q, level_d;
    logic [1:0]                     state_q, state_d;
    logic                           push, pop, rsp_load, timeout_hit;
    logic                           head_wr;
    logic [TWQ_ADDRESS_BITS-1:0]    head_addr;
    logic [TWQ_DATA_BITS-1:0]       head_wdata;
    logic                           tw_start_q, tw_mode_wr_q;
    logic [TWQ_ADDRESS_BITS-1:0]    tw_addr_q;
    logic [TWQ_DATA_BITS-1:0]       tw_wr_data_q;
    logic                           rsp_valid_q;
    logic [TWQ_DATA_BITS-1:0]       rsp_data_q;

    // Ready depends only on the registered level, so a pop cannot make room in the same cycle.
    assign host.out_req_ready = (level_q != LevelFull);
    assign push = host.in_req_valid && host.out_req_ready;
    assign pop  = (state_q == StIdle) && (level_q != '0) && !rsp_valid_q;
    assign {head_wr, head_addr, head_wdata} = fifo_mem[rd_ptr_q];
    assign rsp_load = (state_q == StWaitDone) && !in_tw_in_progress && !tw_mode_wr_q;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LevelOne;
        end else if (pop && !push) begin
            level_d = level_q - LevelOne;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (pop) state_d = StWaitBusy;
            StWaitBusy: if (in_tw_in_progress) state_d = StWaitDone;
            StWaitDone: if (!in_tw_in_progress) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        if (timeout_hit) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge in_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {host.in_req_wr, host.in_req_addr, host.in_req_wdata};
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            tw_start_q   <= 1'b0;
            tw_mode_wr_q <= 1'b0;
            tw_addr_q    <= '0;
            tw_wr_data_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            tw_start_q <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + PtrOne;
                tw_mode_wr_q <= head_wr;
                tw_addr_q    <= head_addr;
                tw_wr_data_q <= head_wdata;
            end
            if (host.in_rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (rsp_load) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= in_tw_rd_data;
            end
            if (timeout_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
            end
        end
    end

`ifdef THREEWIRE_QUEUE_TIMEOUT_EN
    localparam int unsigned WdBits = (TWQ_TIMEOUT_CYCLES > 2) ? $clog2(TWQ_TIMEOUT_CYCLES) : 1;
    localparam logic [WdBits-1:0] WdLast = WdBits'(TWQ_TIMEOUT_CYCLES - 1);
    localparam logic [WdBits-1:0] WdOne  = WdBits'(1);

    logic [WdBits-1:0] wd_cnt_q;
    logic              rsp_err_q;

    assign timeout_hit = (state_q != StIdle) && (wd_cnt_q == WdLast);

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            wd_cnt_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (pop) begin
                wd_cnt_q <= '0;
            end else if (state_q != StIdle) begin
                wd_cnt_q <= wd_cnt_q + WdOne;
            end
            if (timeout_hit) begin
                rsp_err_q <= 1'b1;
            end else if (rsp_load) begin
                rsp_err_q <= 1'b0;
            end
        end
    end

    assign host.out_rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    // Timeout parameter is kept on the port list so both builds share one instantiation.
    assign host.out_rsp_err = (TWQ_TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    assign host.out_rsp_valid = rsp_valid_q;
    assign host.out_rsp_data  = rsp_data_q;
    assign out_fifo_level     = level_q;
    assign out_busy           = (state_q != StIdle) || (level_q != '0) || rsp_valid_q;
    assign out_tw_start       = tw_start_q;
    assign out_tw_mode_wr     = tw_mode_wr_q;
    assign out_tw_addr        = tw_addr_q;
    assign out_tw_wr_data     = tw_wr_data_q;
endmodule

// File: tb/tb_threewire_cmd_queue.sv
// Self-checking bench for threewire_cmd_queue with a behavioural 3-wire master
// and a register-file reference model.
module tb_threewire_cmd_queue;
    localparam int unsigned A = 10;
    localparam int unsigned D = 32;
    localparam int unsigned N = 2;
    localparam int unsigned T = 16;

    typedef struct {
        bit           wr;
        logic [A-1:0] addr;
        logic [D-1:0] data;
    } req_t;

    logic         in_clk = 1'b0;
    logic         in_rst_n;
    logic [N:0]   out_fifo_level;
    logic         out_busy, out_tw_start, out_tw_mode_wr;
    logic [A-1:0] out_tw_addr;
    logic [D-1:0] out_tw_wr_data;
    logic [D-1:0] in_tw_rd_data = '0;
    logic         in_tw_in_progress = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    threewire_cmd_queue_if #(.TWQ_ADDRESS_BITS(A), .TWQ_DATA_BITS(D)) host ();

    threewire_cmd_queue #(
        .TWQ_ADDRESS_BITS(A), .TWQ_DATA_BITS(D),
        .TWQ_FIFO_DEPTH_LOG2(N), .TWQ_TIMEOUT_CYCLES(T)
    ) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .host(host),
        .out_fifo_level(out_fifo_level), .out_busy(out_busy),
        .out_tw_start(out_tw_start), .out_tw_mode_wr(out_tw_mode_wr),
        .out_tw_addr(out_tw_addr), .out_tw_wr_data(out_tw_wr_data),
        .in_tw_rd_data(in_tw_rd_data), .in_tw_in_progress(in_tw_in_progress)
    );

    always #5 in_clk = ~in_clk;

    // Behavioural slave device: a register file behind the 3-wire master.
    logic [D-1:0] dev_mem [int];
    bit           mst_stuck = 1'b0;
    int           mst_len_fixed = 0;
    int           mst_cnt = 0;
    bit           mst_wr;
    logic [A-1:0] mst_addr;
    logic [D-1:0] mst_data;

    function automatic logic [D-1:0] dev_default(int a);
        return 32'hA500_0000 ^ 32'(a);
    endfunction

    always @(posedge in_clk) begin
        if (mst_cnt > 0) begin
            mst_cnt = mst_cnt - 1;
            if (mst_cnt == 0) begin
                in_tw_in_progress <= 1'b0;
                if (mst_wr) dev_mem[int'(mst_addr)] = mst_data;
                else in_tw_rd_data <= dev_mem.exists(int'(mst_addr)) ?
                                      dev_mem[int'(mst_addr)] : dev_default(int'(mst_addr));
            end
        end else if (out_tw_start && !mst_stuck) begin
            in_tw_in_progress <= 1'b1;
            mst_cnt  = (mst_len_fixed > 0) ? mst_len_fixed : int'($urandom_range(1, 4));
            mst_wr   = out_tw_mode_wr;
            mst_addr = out_tw_addr;
            mst_data = out_tw_wr_data;
        end
    end

    task automatic push_req(input bit wr, input logic [A-1:0] addr, input logic [D-1:0] data,
                            output bit acc);
        @(negedge in_clk);
        host.in_req_valid = 1'b1;
        host.in_req_wr    = wr;
        host.in_req_addr  = addr;
        host.in_req_wdata = data;
        acc = host.out_req_ready;
        @(posedge in_clk);
        #1 host.in_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        in_rst_n = 1'b0;
        host.in_req_valid = 1'b0; host.in_req_wr = 1'b0;
        host.in_req_addr = '0; host.in_req_wdata = '0; host.in_rsp_ready = 1'b0;
        repeat (3) @(posedge in_clk);
        @(negedge in_clk);
        n_checks++;
        if ({host.out_req_ready, host.out_rsp_valid, host.out_rsp_err, out_busy,
             out_tw_start, out_tw_mode_wr} !== 6'b100000)
            $display("FAIL reset_flags got %b exp 100000", {host.out_req_ready,
                     host.out_rsp_valid, host.out_rsp_err, out_busy, out_tw_start, out_tw_mode_wr});
        else n_pass++;
        n_checks++;
        if (out_fifo_level !== 3'd0) $display("FAIL reset_level got %0d exp 0", out_fifo_level);
        else n_pass++;
        n_checks++;
        if ({host.out_rsp_data, out_tw_addr, out_tw_wr_data} !== '0)
            $display("FAIL reset_data got %h/%h/%h exp 0", host.out_rsp_data, out_tw_addr,
                     out_tw_wr_data);
        else n_pass++;
        in_rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        bit acc;
        int starts = 0;
        int k = 0;
        dev_mem[10'h155] = 32'hDEAD_BEEF;
        host.in_rsp_ready = 1'b0;
        push_req(1'b0, 10'h155, '0, acc);
        @(negedge in_clk);
        n_checks++;
        if (out_tw_start !== 1'b0) $display("FAIL rd_start_early got %b exp 0", out_tw_start);
        else n_pass++;
        @(negedge in_clk);
        n_checks++;
        if ({out_tw_start, out_tw_mode_wr, out_tw_addr} !== {1'b1, 1'b0, 10'h155})
            $display("FAIL rd_issue got start=%b wr=%b addr=%h exp 1/0/155", out_tw_start,
                     out_tw_mode_wr, out_tw_addr);
        else n_pass++;
        while (!host.out_rsp_valid && k < 50) begin
            @(negedge in_clk);
            k++;
            if (out_tw_start) starts++;
        end
        n_checks++;
        if (starts !== 0) $display("FAIL rd_extra_start got %0d exp 0", starts);
        else n_pass++;
        n_checks++;
        if ({host.out_rsp_valid, host.out_rsp_err, host.out_rsp_data} !== {2'b10, 32'hDEAD_BEEF})
            $display("FAIL rd_rsp got v=%b e=%b d=%h exp 1/0/deadbeef", host.out_rsp_valid,
                     host.out_rsp_err, host.out_rsp_data);
        else n_pass++;
        host.in_rsp_ready = 1'b1;
        @(negedge in_clk);
        n_checks++;
        if (host.out_rsp_valid !== 1'b0) $display("FAIL rd_rsp_clear got 1 exp 0");
        else n_pass++;
    endtask

    task automatic test_queued_writes();
        bit acc;
        int idx = 0;
        int rsps = 0;
        int k = 0;
        host.in_rsp_ready = 1'b0;
        push_req(1'b0, 10'h3FF, '0, acc);
        while (!host.out_rsp_valid && k < 50) begin @(negedge in_clk); k++; end
        for (int i = 1; i <= 4; i++) begin
            push_req(1'b1, A'(i), 32'h1111_1111 * i, acc);
            n_checks++;
            if (acc !== 1'b1) $display("FAIL fill_accept%0d got 0 exp 1", i);
            else n_pass++;
        end
        @(negedge in_clk);
        n_checks++;
        if ({out_fifo_level, host.out_req_ready} !== {3'd4, 1'b0})
            $display("FAIL fill_full got lvl=%0d rdy=%b exp 4/0", out_fifo_level,
                     host.out_req_ready);
        else n_pass++;
        push_req(1'b1, 10'h005, 32'h5555_5555, acc);
        n_checks++;
        if (acc !== 1'b0) $display("FAIL fill_refuse got accepted exp refused");
        else n_pass++;
        @(negedge in_clk);
        host.in_rsp_ready = 1'b1;
        k = 0;
        while (k < 300) begin
            @(negedge in_clk);
            k++;
            if (host.out_rsp_valid) rsps++;
            if (out_tw_start) begin
                idx++;
                n_checks++;
                if ({out_tw_mode_wr, out_tw_addr, out_tw_wr_data} !==
                    {1'b1, A'(idx), 32'h1111_1111 * idx})
                    $display("FAIL wr_issue%0d got wr=%b a=%h d=%h", idx, out_tw_mode_wr,
                             out_tw_addr, out_tw_wr_data);
                else n_pass++;
            end
            if (idx >= 4 && !out_busy) break;
        end
        n_checks++;
        if ({idx, rsps} !== {32'd4, 32'd0})
            $display("FAIL wr_summary got starts=%0d rsps=%0d exp 4/0", idx, rsps);
        else n_pass++;
    endtask

    task automatic test_back_to_back_backpressure();
        bit acc;
        int k = 0;
        int starts = 0;
        dev_mem[10'h020] = 32'h1234_5678;
        host.in_rsp_ready = 1'b0;
        push_req(1'b0, 10'h020, '0, acc);
        push_req(1'b1, 10'h021, 32'hCAFE_F00D, acc);
        while (!host.out_rsp_valid && k < 50) begin @(negedge in_clk); k++; end
        n_checks++;
        if (host.out_rsp_data !== 32'h1234_5678)
            $display("FAIL bp_rdata got %h exp 12345678", host.out_rsp_data);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge in_clk);
            if (out_tw_start) starts++;
        end
        n_checks++;
        if ({starts, host.out_rsp_valid, out_fifo_level} !== {32'd0, 1'b1, 3'd1})
            $display("FAIL bp_blocked got starts=%0d v=%b lvl=%0d exp 0/1/1", starts,
                     host.out_rsp_valid, out_fifo_level);
        else n_pass++;
        host.in_rsp_ready = 1'b1;
        @(negedge in_clk);
        n_checks++;
        if (host.out_rsp_valid !== 1'b0) $display("FAIL bp_clear got 1 exp 0");
        else n_pass++;
        k = 0;
        while (!out_tw_start && k < 10) begin @(negedge in_clk); k++; end
        n_checks++;
        if ({out_tw_start, out_tw_mode_wr, out_tw_addr, out_tw_wr_data} !==
            {2'b11, 10'h021, 32'hCAFE_F00D})
            $display("FAIL bp_wr_issue got s=%b wr=%b a=%h d=%h", out_tw_start, out_tw_mode_wr,
                     out_tw_addr, out_tw_wr_data);
        else n_pass++;
        k = 0;
        while (out_busy && k < 50) begin @(negedge in_clk); k++; end
    endtask

    task automatic test_push_pop_same_cycle();
        bit acc;
        int k = 0;
        host.in_rsp_ready = 1'b0;
        push_req(1'b0, 10'h030, '0, acc);
        while (!host.out_rsp_valid && k < 50) begin @(negedge in_clk); k++; end
        push_req(1'b1, 10'h031, 32'h3131_3131, acc);
        @(negedge in_clk);
        host.in_rsp_ready = 1'b1;
        @(negedge in_clk);
        host.in_rsp_ready = 1'b0;
        host.in_req_valid = 1'b1;
        host.in_req_wr    = 1'b1;
        host.in_req_addr  = 10'h032;
        host.in_req_wdata = 32'h3232_3232;
        @(posedge in_clk);
        #1 host.in_req_valid = 1'b0;
        @(negedge in_clk);
        n_checks++;
        if ({out_fifo_level, out_tw_start, out_tw_addr} !== {3'd1, 1'b1, 10'h031})
            $display("FAIL pushpop got lvl=%0d s=%b a=%h exp 1/1/031", out_fifo_level,
                     out_tw_start, out_tw_addr);
        else n_pass++;
        host.in_rsp_ready = 1'b1;
        k = 0;
        while (out_busy && k < 100) begin @(negedge in_clk); k++; end
        n_checks++;
        if (out_busy !== 1'b0) $display("FAIL pushpop_drain got busy=1 exp 0");
        else n_pass++;
    endtask

    task automatic test_random();
        req_t         exp_issue[$];
        logic [D-1:0] exp_rsp[$];
        logic [D-1:0] ref_mem [int];
        req_t         r;
        bit           rsp_seen = 1'b0;
        int           sent = 0;
        int           cyc = 0;
        int           a;
        forever begin
            @(negedge in_clk);
            cyc++;
            if (out_tw_start) begin
                n_checks++;
                if (exp_issue.size() == 0) begin
                    $display("FAIL rnd_issue unexpected start a=%h", out_tw_addr);
                end else begin
                    r = exp_issue.pop_front();
                    if ({out_tw_mode_wr, out_tw_addr, out_tw_wr_data} !== {r.wr, r.addr, r.data})
                        $display("FAIL rnd_issue got %b/%h/%h exp %b/%h/%h", out_tw_mode_wr,
                                 out_tw_addr, out_tw_wr_data, r.wr, r.addr, r.data);
                    else n_pass++;
                end
            end
            if (host.out_rsp_valid && !rsp_seen) begin
                rsp_seen = 1'b1;
                n_checks++;
                if (exp_rsp.size() == 0) $display("FAIL rnd_rsp unexpected response");
                else if ({host.out_rsp_err, host.out_rsp_data} !== {1'b0, exp_rsp[0]})
                    $display("FAIL rnd_rsp got e=%b d=%h exp 0/%h", host.out_rsp_err,
                             host.out_rsp_data, exp_rsp[0]);
                else n_pass++;
                if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
            end
            if ((sent >= 40 && exp_issue.size() == 0 && exp_rsp.size() == 0 && !out_busy) ||
                cyc >= 3000) break;
            host.in_req_valid = (sent < 40) && ($urandom_range(0, 1) == 1);
            host.in_req_wr    = ($urandom_range(0, 1) == 1);
            host.in_req_addr  = 10'h200 + A'($urandom_range(0, 7));
            host.in_req_wdata = $urandom;
            host.in_rsp_ready = ($urandom_range(0, 3) != 0);
            if (host.in_req_valid && host.out_req_ready) begin
                sent++;
                r.wr = host.in_req_wr; r.addr = host.in_req_addr; r.data = host.in_req_wdata;
                exp_issue.push_back(r);
                a = int'(r.addr);
                if (r.wr) ref_mem[a] = r.data;
                else exp_rsp.push_back(ref_mem.exists(a) ? ref_mem[a] : dev_default(a));
            end
            if (host.out_rsp_valid && host.in_rsp_ready) rsp_seen = 1'b0;
        end
        host.in_req_valid = 1'b0;
        host.in_rsp_ready = 1'b1;
        n_checks++;
        if (cyc >= 3000 || exp_issue.size() != 0 || exp_rsp.size() != 0)
            $display("FAIL rnd_drain got cyc=%0d issue_left=%0d rsp_left=%0d", cyc,
                     exp_issue.size(), exp_rsp.size());
        else n_pass++;
    endtask

`ifdef THREEWIRE_QUEUE_TIMEOUT_EN
    task automatic test_timeout();
        bit acc;
        int k = 0;
        mst_stuck = 1'b1;
        host.in_rsp_ready = 1'b1;
        push_req(1'b0, 10'h040, '0, acc);
        push_req(1'b1, 10'h041, 32'h4141_4141, acc);
        while (!out_tw_start && k < 10) begin @(negedge in_clk); k++; end
        k = 0;
        while (!host.out_rsp_valid && k < 40) begin @(negedge in_clk); k++; end
        n_checks++;
        if ({k, host.out_rsp_err, host.out_rsp_data} !== {32'd16, 1'b1, 32'd0})
            $display("FAIL to_rd got cycles=%0d e=%b d=%h exp 16/1/0", k, host.out_rsp_err,
                     host.out_rsp_data);
        else n_pass++;
        k = 0;
        while (!out_tw_start && k < 10) begin @(negedge in_clk); k++; end
        n_checks++;
        if ({out_tw_start, out_tw_mode_wr, out_tw_addr} !== {2'b11, 10'h041})
            $display("FAIL to_next got s=%b wr=%b a=%h exp 1/1/041", out_tw_start,
                     out_tw_mode_wr, out_tw_addr);
        else n_pass++;
        k = 0;
        while (!host.out_rsp_valid && k < 40) begin @(negedge in_clk); k++; end
        n_checks++;
        if ({host.out_rsp_valid, host.out_rsp_err} !== 2'b11)
            $display("FAIL to_wr got v=%b e=%b exp 1/1", host.out_rsp_valid, host.out_rsp_err);
        else n_pass++;
        k = 0;
        while (out_busy && k < 20) begin @(negedge in_clk); k++; end
        mst_stuck = 1'b0;
    endtask
`else
    task automatic test_timeout();
        bit acc;
        int rsps = 0;
        mst_stuck = 1'b1;
        host.in_rsp_ready = 1'b1;
        push_req(1'b0, 10'h040, '0, acc);
        for (int i = 0; i < 60; i++) begin
            @(negedge in_clk);
            if (host.out_rsp_valid || host.out_rsp_err) rsps++;
        end
        n_checks++;
        if ({rsps, out_busy} !== {32'd0, 1'b1})
            $display("FAIL stall got rsps=%0d busy=%b exp 0/1", rsps, out_busy);
        else n_pass++;
        @(negedge in_clk);
        in_rst_n = 1'b0;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        mst_stuck = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_op();
        bit acc;
        int k = 0;
        int events = 0;
        mst_len_fixed = 30;
        host.in_rsp_ready = 1'b1;
        push_req(1'b0, 10'h050, '0, acc);
        push_req(1'b1, 10'h051, 32'h5151_5151, acc);
        push_req(1'b1, 10'h052, 32'h5252_5252, acc);
        while (!in_tw_in_progress && k < 20) begin @(negedge in_clk); k++; end
        repeat (3) @(negedge in_clk);
        n_checks++;
        if ({in_tw_in_progress, out_fifo_level} !== {1'b1, 3'd2})
            $display("FAIL rst_pre got prog=%b lvl=%0d exp 1/2", in_tw_in_progress,
                     out_fifo_level);
        else n_pass++;
        in_rst_n = 1'b0;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        n_checks++;
        if ({out_fifo_level, out_busy, host.out_rsp_valid, host.out_req_ready} !==
            {3'd0, 3'b001})
            $display("FAIL rst_mid got lvl=%0d busy=%b v=%b rdy=%b exp 0/0/0/1", out_fifo_level,
                     out_busy, host.out_rsp_valid, host.out_req_ready);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            @(negedge in_clk);
            if (host.out_rsp_valid || out_tw_start) events++;
        end
        n_checks++;
        if (events !== 0) $display("FAIL rst_after got events=%0d exp 0", events);
        else n_pass++;
        mst_len_fixed = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got no finish exp finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_queued_writes();
        test_back_to_back_backpressure();
        test_push_pop_same_cycle();
        test_random();
        test_timeout();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
